ahb_copy_dma: RTL and testbench
===============================

Name: ahb_copy_dma

Overview:
- AHB-Lite manager (initiator) that copies a block of XLEN-bit words from a source address range to a destination address range over the uncore bus.
- Primary use: boot-time copy of an image out of the on-chip ROM subordinate into RAM.
- Fronted by a simple Start/Busy/Done control interface driven by a configuration register block or boot sequencer.
- Issues single-beat, non-pipelined NONSEQ transfers, alternating read then write per word.

Parameters:
- P, cvw_t, core configuration record; uses P.XLEN and P.PA_BITS.
- LEN_BITS, 16, width of the word-count input; max copy is 2^LEN_BITS-1 words.

Ports:
- HCLK  input  1  bus clock; all state updates on rising edge.
- HRESETn  input  1  asynchronous active-low reset.
- Start  input  1  one-cycle request; sampled only in IDLE.
- SrcAddr  input  P.PA_BITS  source byte address; low OFFSET bits ignored, treated as 0.
- DstAddr  input  P.PA_BITS  destination byte address; low OFFSET bits ignored, treated as 0.
- WordCount  input  LEN_BITS  number of XLEN words to copy.
- Busy  output  1  high from the cycle after an accepted Start until Done.
- Done  output  1  one-cycle completion pulse, on success or error.
- Error  output  1  sticky; set on an HRESP error, cleared by the next accepted Start.
- HADDR  output  P.PA_BITS  AHB address.
- HTRANS  output  2  IDLE=2'b00 or NONSEQ=2'b10 only.
- HWRITE  output  1  AHB write.
- HSIZE  output  3  constant $clog2(P.XLEN/8).
- HBURST  output  3  constant 3'b000 (SINGLE).
- HWDATA  output  P.XLEN  write data.
- HRDATA  input  P.XLEN  read data.
- HREADY  input  1  transfer ready.
- HRESP  input  1  error response.

Behaviour:
- Reset (HRESETn=0, asynchronous): state IDLE; Busy=0, Done=0, Error=0, HTRANS=IDLE, HWRITE=0, HADDR=0, HWDATA=0; counters and data buffer cleared. Reset mid-copy abandons the copy with no Done pulse.
- OFFSET = $clog2(P.XLEN/8). Address registers increment by P.XLEN/8 and wrap modulo 2^PA_BITS.
- States: IDLE, RDA (read address phase), RDD (read data phase), WRA (write address phase), WRD (write data phase).
- IDLE:
  - Start=1 with WordCount!=0: latch SrcAddr, DstAddr and WordCount; clear Error; go to RDA.
  - Start=1 with WordCount==0: Done pulses next cycle, Busy stays 0, no bus traffic, Error cleared.
- RDA: HTRANS=NONSEQ, HWRITE=0, HADDR=src. Hold all address-phase outputs stable until HREADY=1, then go to RDD.
- RDD: HTRANS=IDLE.
  - HREADY=1, HRESP=0: capture HRDATA into the buffer; go to WRA.
- WRA: HTRANS=NONSEQ, HWRITE=1, HADDR=dst. Hold until HREADY=1, then go to WRD.
- WRD: HTRANS=IDLE, HWDATA=buffer, held stable until HREADY=1. On HREADY=1, HRESP=0:
  - src+=XLEN/8, dst+=XLEN/8, count-=1.
  - count was 1: go to IDLE and pulse Done next cycle.
  - otherwise: go to RDA.
- Error handling (RDD or WRD): HRESP=1 with HREADY=0 is the first error cycle; wait. On HRESP=1 with HREADY=1: set Error, go to IDLE, pulse Done next cycle. No further transfers; buffer not written on a read error.
- Start while Busy is ignored.
- Timing with a zero-wait subordinate:
  - Start accepted in cycle 0; RDA in cycle 1; 4 cycles per word.
  - Done high in cycle 4N+1; Busy high in cycles 1..4N.
- Wait states extend RDA/RDD/WRA/WRD one cycle per HREADY=0 cycle.

Decomposition:
- Shared cvw package: HTRANS encodings (HTRANS_IDLE, HTRANS_NONSEQ) and HBURST_SINGLE constant.
- State enum typedef is local to the module.
- No sub-module. Address, count and buffer registers use the existing enabled/resettable flop primitives (flopenr).

Test Plan:
- XLEN=64, zero-wait RAM model; Src=0x1000, Dst=0x8000_0000, WordCount=3 -> reads 0x1000/0x1008/0x1010, writes at 0x8000_0000/08/10 carry matching data; Done in cycle 13; Error=0.
- WordCount=0 -> Done in cycle 1, Busy never high, HTRANS stays IDLE.
- Subordinate inserts 2 wait states on each read data phase, copy 2 words -> HADDR/HTRANS/HWDATA stable through waits; Done in cycle 13; data correct.
- Second read returns HRESP error (cycle 1: HREADY=0, HRESP=1; cycle 2: HREADY=1, HRESP=1) with WordCount=4 -> only word 0 written; Error=1; Done pulses once; next Start clears Error.
- Start pulsed again while Busy -> ignored; counts and addresses unchanged.
- HRESETn asserted during WRA -> outputs go to reset values immediately; no Done; subsequent Start copies normally.
- Src=2^PA_BITS-8, WordCount=2 -> second read address wraps to 0x0.

Source files
------------

// File: rtl/ahb_copy_dma_pkg.sv
// -----------------------------------------------------------------------------
// ahb_copy_dma_pkg
//
// Shared definitions for the AHB-Lite copy DMA:
//   - cvw_t       : core configuration record (bus data width, physical
//                   address width) passed to the DMA as parameter P.
//   - CVW_RV64    : default configuration (64-bit data, 32-bit addresses).
//   - HTRANS_*    : AHB transfer-type encodings used by the manager.
//   - HBURST_SINGLE : the only burst type the DMA issues.
// -----------------------------------------------------------------------------
package ahb_copy_dma_pkg;

    // Core configuration record. Field names follow the core's configuration
    // naming so that P.XLEN / P.PA_BITS read the same as in the rest of the core.
    typedef struct packed {
        int unsigned XLEN;     // data word width in bits
        int unsigned PA_BITS;  // physical address width in bits
    } cvw_t;

    localparam cvw_t CVW_RV64 = '{XLEN: 32'd64, PA_BITS: 32'd32};

    // AHB-Lite transfer types. BUSY and SEQ are never generated.
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    // AHB-Lite burst type: single transfers only.
    localparam logic [2:0] HBURST_SINGLE = 3'b000;

endpackage : ahb_copy_dma_pkg

// File: rtl/ahb_copy_dma_flopenr.sv
// -----------------------------------------------------------------------------
// ahb_copy_dma_flopenr
//
// Enabled flop with asynchronous active-low clear. Used for the DMA's
// address, count and data-buffer registers.
//
// Ports:
//   clk    in   clock, rising edge
//   rst_n  in   asynchronous active-low clear (q <= 0)
//   en     in   load enable
//   d      in   next value, loaded when en=1
//   q      out  registered value
// -----------------------------------------------------------------------------
module ahb_copy_dma_flopenr #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // NOTE: sequential state always uses non-blocking assignment so every flop
    // samples pre-edge values, independent of block evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule : ahb_copy_dma_flopenr

// File: rtl/ahb_copy_dma.sv
// -----------------------------------------------------------------------------
// ahb_copy_dma
//
// AHB-Lite manager that copies WordCount XLEN-bit words from a source address
// range to a destination address range, one single-beat non-pipelined NONSEQ
// read followed by one NONSEQ write per word. Typical use is copying a boot
// image out of ROM into RAM under control of a boot sequencer.
//
// Parameters:
//   P         core configuration record (uses P.XLEN, P.PA_BITS)
//   LEN_BITS  width of WordCount; largest copy is 2^LEN_BITS-1 words
//
// Ports:
//   HCLK       in   bus clock
//   HRESETn    in   asynchronous active-low reset
//   Start      in   one-cycle copy request, only looked at while idle
//   SrcAddr    in   source byte address (sub-word bits ignored)
//   DstAddr    in   destination byte address (sub-word bits ignored)
//   WordCount  in   number of words to copy
//   Busy       out  copy in progress (cycle after accepted Start until Done)
//   Done       out  one-cycle completion pulse (success or error)
//   Error      out  sticky bus-error flag, cleared by the next accepted Start
//   HADDR      out  AHB address
//   HTRANS     out  AHB transfer type (IDLE / NONSEQ)
//   HWRITE     out  AHB write
//   HSIZE      out  AHB size, constant log2(XLEN/8)
//   HBURST     out  AHB burst, constant SINGLE
//   HWDATA     out  AHB write data
//   HRDATA     in   AHB read data
//   HREADY     in   AHB transfer ready
//   HRESP      in   AHB error response
//
// Per word with a zero-wait subordinate: RDA, RDD, WRA, WRD = 4 cycles. Each
// HREADY=0 cycle stretches the current phase by one cycle.
// -----------------------------------------------------------------------------
module ahb_copy_dma
    import ahb_copy_dma_pkg::*;
#(
    parameter cvw_t P        = CVW_RV64,
    parameter int   LEN_BITS = 16
) (
    input  logic                 HCLK,
    input  logic                 HRESETn,
    input  logic                 Start,
    input  logic [P.PA_BITS-1:0] SrcAddr,
    input  logic [P.PA_BITS-1:0] DstAddr,
    input  logic [LEN_BITS-1:0]  WordCount,
    output logic                 Busy,
    output logic                 Done,
    output logic                 Error,
    output logic [P.PA_BITS-1:0] HADDR,
    output logic [1:0]           HTRANS,
    output logic                 HWRITE,
    output logic [2:0]           HSIZE,
    output logic [2:0]           HBURST,
    output logic [P.XLEN-1:0]    HWDATA,
    input  logic [P.XLEN-1:0]    HRDATA,
    input  logic                 HREADY,
    input  logic                 HRESP
);

    localparam int XLEN    = P.XLEN;
    localparam int PA_BITS = P.PA_BITS;
    localparam int BYTES   = XLEN / 8;

    // Address step per word, and a mask that forces word alignment.
    localparam logic [PA_BITS-1:0] STEP       = PA_BITS'(BYTES);
    localparam logic [PA_BITS-1:0] ALIGN_MASK = ~PA_BITS'(BYTES - 1);

    typedef enum logic [2:0] {
        S_IDLE,  // waiting for Start
        S_RDA,   // read address phase
        S_RDD,   // read data phase
        S_WRA,   // write address phase
        S_WRD    // write data phase
    } state_t;

    state_t state;

    logic [PA_BITS-1:0]  src_q, dst_q;
    logic [PA_BITS-1:0]  src_d, dst_d;
    logic [PA_BITS-1:0]  src_next, dst_next;
    logic [PA_BITS-1:0]  src_start, dst_start;
    logic [LEN_BITS-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0]     buf_q;

    logic start_go;   // Start accepted with a non-empty copy
    logic rd_ok;      // read data phase completes without error
    logic wr_ok;      // write data phase completes without error
    logic ptr_load;   // address/count registers load this cycle
    logic last_word;  // the word now being written is the final one

    // ------------------------------------------------------------------
    // Datapath control
    // ------------------------------------------------------------------
    assign start_go  = (state == S_IDLE) && Start && (WordCount != '0);
    assign rd_ok     = (state == S_RDD) && HREADY && !HRESP;
    assign wr_ok     = (state == S_WRD) && HREADY && !HRESP;
    assign ptr_load  = start_go || wr_ok;
    assign last_word = (cnt_q == LEN_BITS'(1));

    assign src_start = SrcAddr & ALIGN_MASK;
    assign dst_start = DstAddr & ALIGN_MASK;

    // Increments wrap naturally at the top of the physical address space.
    assign src_next  = src_q + STEP;
    assign dst_next  = dst_q + STEP;

    assign src_d = start_go ? src_start : src_next;
    assign dst_d = start_go ? dst_start : dst_next;
    assign cnt_d = start_go ? WordCount : (cnt_q - LEN_BITS'(1));

    ahb_copy_dma_flopenr #(.WIDTH(PA_BITS)) u_src_reg (
        .clk   (HCLK),
        .rst_n (HRESETn),
        .en    (ptr_load),
        .d     (src_d),
        .q     (src_q)
    );

    ahb_copy_dma_flopenr #(.WIDTH(PA_BITS)) u_dst_reg (
        .clk   (HCLK),
        .rst_n (HRESETn),
        .en    (ptr_load),
        .d     (dst_d),
        .q     (dst_q)
    );

    ahb_copy_dma_flopenr #(.WIDTH(LEN_BITS)) u_cnt_reg (
        .clk   (HCLK),
        .rst_n (HRESETn),
        .en    (ptr_load),
        .d     (cnt_d),
        .q     (cnt_q)
    );

    // NOTE: the one-word data buffer is a plain register, not a memory, and is
    // cleared on reset because it drives HWDATA, which must read 0 out of reset.
    // It only loads on an error-free read, so a failed read leaves it untouched.
    ahb_copy_dma_flopenr #(.WIDTH(XLEN)) u_buf_reg (
        .clk   (HCLK),
        .rst_n (HRESETn),
        .en    (rd_ok),
        .d     (HRDATA),
        .q     (buf_q)
    );

    // The buffer is stable from the end of the read data phase until the
    // next read completes, so it covers the whole write address/data phase.
    assign HWDATA = buf_q;
    assign HSIZE  = 3'($clog2(BYTES));
    assign HBURST = HBURST_SINGLE;

    // ------------------------------------------------------------------
    // Control FSM with registered bus and status outputs
    // ------------------------------------------------------------------
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state  <= S_IDLE;
            Busy   <= 1'b0;
            Done   <= 1'b0;
            Error  <= 1'b0;
            HTRANS <= HTRANS_IDLE;
            HWRITE <= 1'b0;
            HADDR  <= '0;
        end else begin
            Done <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (Start) begin
                        Error <= 1'b0;
                        if (WordCount != '0) begin
                            state  <= S_RDA;
                            Busy   <= 1'b1;
                            HTRANS <= HTRANS_NONSEQ;
                            HWRITE <= 1'b0;
                            HADDR  <= src_start;
                        end else begin
                            // Empty copy: acknowledge without touching the bus.
                            Done <= 1'b1;
                        end
                    end
                end

                S_RDA: begin
                    // Address-phase outputs hold until the subordinate accepts.
                    if (HREADY) begin
                        state  <= S_RDD;
                        HTRANS <= HTRANS_IDLE;
                    end
                end

                S_RDD: begin
                    // HRESP=1 with HREADY=0 is the first error cycle: keep waiting.
                    if (HREADY) begin
                        if (HRESP) begin
                            state  <= S_IDLE;
                            Busy   <= 1'b0;
                            Done   <= 1'b1;
                            Error  <= 1'b1;
                        end else begin
                            state  <= S_WRA;
                            HTRANS <= HTRANS_NONSEQ;
                            HWRITE <= 1'b1;
                            HADDR  <= dst_q;
                        end
                    end
                end

                S_WRA: begin
                    if (HREADY) begin
                        state  <= S_WRD;
                        HTRANS <= HTRANS_IDLE;
                    end
                end

                S_WRD: begin
                    if (HREADY) begin
                        if (HRESP) begin
                            state  <= S_IDLE;
                            Busy   <= 1'b0;
                            Done   <= 1'b1;
                            Error  <= 1'b1;
                            HWRITE <= 1'b0;
                        end else if (last_word) begin
                            state  <= S_IDLE;
                            Busy   <= 1'b0;
                            Done   <= 1'b1;
                            HWRITE <= 1'b0;
                        end else begin
                            // src_q advances on this same edge; present the
                            // incremented value directly as the next read address.
                            state  <= S_RDA;
                            HTRANS <= HTRANS_NONSEQ;
                            HWRITE <= 1'b0;
                            HADDR  <= src_next;
                        end
                    end
                end

                default: begin
                    state  <= S_IDLE;
                    Busy   <= 1'b0;
                    HTRANS <= HTRANS_IDLE;
                    HWRITE <= 1'b0;
                end
            endcase
        end
    end

endmodule : ahb_copy_dma

// File: tb/tb_ahb_copy_dma.sv
// -----------------------------------------------------------------------------
// tb_ahb_copy_dma
//
// Bench for ahb_copy_dma (XLEN=64, PA_BITS=32). A subordinate model answers
// the bus with configurable wait states and one optional read error. Each
// directed copy pushes its expected bus transfers and its expected Done
// record (error flag, Done cycle, number of Busy cycles) into queues; a
// separate monitor pops and compares as transfers complete and Done pulses.
// -----------------------------------------------------------------------------
module tb_ahb_copy_dma;
    import ahb_copy_dma_pkg::*;

    localparam int XLEN     = 64;
    localparam int PA       = 32;
    localparam int LEN_BITS = 16;
    localparam logic [XLEN-1:0] JUNK = 64'hBADC_0FFE_E0DD_F00D;

    logic                HCLK = 1'b0;
    logic                HRESETn = 1'b0;
    logic                Start = 1'b0;
    logic [PA-1:0]       SrcAddr = '0;
    logic [PA-1:0]       DstAddr = '0;
    logic [LEN_BITS-1:0] WordCount = '0;
    logic                Busy, Done, Error;
    logic [PA-1:0]       HADDR;
    logic [1:0]          HTRANS;
    logic                HWRITE;
    logic [2:0]          HSIZE, HBURST;
    logic [XLEN-1:0]     HWDATA;
    logic [XLEN-1:0]     HRDATA = JUNK;
    logic                HREADY = 1'b1;
    logic                HRESP = 1'b0;

    ahb_copy_dma #(.P(CVW_RV64), .LEN_BITS(LEN_BITS)) dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .Start     (Start),
        .SrcAddr   (SrcAddr),
        .DstAddr   (DstAddr),
        .WordCount (WordCount),
        .Busy      (Busy),
        .Done      (Done),
        .Error     (Error),
        .HADDR     (HADDR),
        .HTRANS    (HTRANS),
        .HWRITE    (HWRITE),
        .HSIZE     (HSIZE),
        .HBURST    (HBURST),
        .HWDATA    (HWDATA),
        .HRDATA    (HRDATA),
        .HREADY    (HREADY),
        .HRESP     (HRESP)
    );

    always #5 HCLK = ~HCLK;

    // ------------------------------------------------------------------
    // Bookkeeping
    // ------------------------------------------------------------------
    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;
    int start_cyc = 0;

    always @(posedge HCLK) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        bit              write;
        logic [PA-1:0]   addr;
        logic [XLEN-1:0] data;
        bit              err;
    } xfer_t;

    typedef struct {
        bit err;
        int done_cycle;
        int busy_cycles;
    } done_t;

    xfer_t exp_xfer[$];
    done_t exp_done[$];

    // Memory seen by the subordinate: written words are stored, everything
    // else reads back as an address-derived pattern.
    logic [XLEN-1:0] mem [logic [PA-1:0]];

    function automatic logic [XLEN-1:0] mem_word(input logic [PA-1:0] a);
        if (mem.exists(a)) return mem[a];
        return {a ^ 32'h5A5A_0000, ~a};
    endfunction

    // ------------------------------------------------------------------
    // Subordinate model: drives HREADY/HRESP/HRDATA at the falling edge
    // ------------------------------------------------------------------
    int rd_data_waits = 0;   // wait states on each read data phase
    int wr_addr_waits = 0;   // wait states on each write address phase
    int err_read_num  = 0;   // 1-based read index that gets an error, 0 = none
    int reads_seen    = 0;

    bit            dp_active = 1'b0;
    bit            dp_write  = 1'b0;
    bit            dp_err    = 1'b0;
    logic [PA-1:0] dp_addr   = '0;
    int            dp_wait   = 0;
    int            aw_cnt    = 0;

    always @(negedge HCLK) begin
        HRDATA = JUNK;
        if (!HRESETn) begin
            dp_active = 1'b0;
            aw_cnt    = 0;
            HREADY    = 1'b1;
            HRESP     = 1'b0;
        end else if (dp_active) begin
            HRESP = dp_err;
            if (dp_wait > 0) begin
                HREADY = 1'b0;
                dp_wait--;
            end else begin
                HREADY = 1'b1;
                if (!dp_write && !dp_err) HRDATA = mem_word(dp_addr);
                if (dp_write && !dp_err) mem[dp_addr] = HWDATA;
                dp_active = 1'b0;
            end
        end else begin
            HRESP = 1'b0;
            if (HTRANS == HTRANS_NONSEQ) begin
                if (HWRITE && aw_cnt < wr_addr_waits) begin
                    HREADY = 1'b0;
                    aw_cnt++;
                end else begin
                    HREADY    = 1'b1;
                    aw_cnt    = 0;
                    dp_active = 1'b1;
                    dp_write  = HWRITE;
                    dp_addr   = HADDR;
                    if (!HWRITE) begin
                        reads_seen++;
                        dp_err  = (reads_seen == err_read_num);
                        dp_wait = dp_err ? 1 : rd_data_waits;
                    end else begin
                        dp_err  = 1'b0;
                        dp_wait = 0;
                    end
                end
            end else begin
                HREADY = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Monitor: samples 1 time unit after the falling edge
    // ------------------------------------------------------------------
    bit              mon_dp = 1'b0;
    bit              mon_write = 1'b0;
    logic [PA-1:0]   mon_addr = '0;
    logic [XLEN-1:0] hwdata_hold = '0;
    int              busy_cnt = 0;

    always @(negedge HCLK) begin
        xfer_t e;
        done_t d;
        #1;
        if (!HRESETn) begin
            mon_dp   = 1'b0;
            busy_cnt = 0;
        end else begin
            if (Busy) busy_cnt++;

            if (mon_dp) begin
                check("data_phase_htrans_idle", 64'(HTRANS), 64'(HTRANS_IDLE));
                check("data_phase_hwdata_stable", HWDATA, hwdata_hold);
                if (HREADY) begin
                    mon_dp = 1'b0;
                    if (exp_xfer.size() == 0) begin
                        n_vec++;
                        n_bad++;
                        $display("FAIL unexpected_xfer: got write=%0d addr=%0h, expected no transfer",
                                 mon_write, mon_addr);
                    end else begin
                        e = exp_xfer.pop_front();
                        check("xfer_hwrite", 64'(mon_write), 64'(e.write));
                        check("xfer_haddr", 64'(mon_addr), 64'(e.addr));
                        check("xfer_hresp", 64'(HRESP), 64'(e.err));
                        if (e.write) check("xfer_hwdata", HWDATA, e.data);
                    end
                end
            end else if (HTRANS == HTRANS_NONSEQ && HREADY) begin
                mon_dp      = 1'b1;
                mon_write   = HWRITE;
                mon_addr    = HADDR;
                hwdata_hold = HWDATA;
            end

            if (Done) begin
                if (exp_done.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL unexpected_done: got Done=1 at cycle %0d, expected no Done", cyc);
                end else begin
                    d = exp_done.pop_front();
                    check("done_error", 64'(Error), 64'(d.err));
                    check("done_cycle", 64'(cyc - start_cyc), 64'(d.done_cycle));
                    check("busy_cycles", 64'(busy_cnt), 64'(d.busy_cycles));
                end
                busy_cnt = 0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    // Queue the transfers of one copy. err_read is the 1-based read that
    // fails (0 = none); the copy stops after that read.
    task automatic expect_copy(input logic [PA-1:0] src, input logic [PA-1:0] dst,
                               input int n, input int err_read);
        logic [PA-1:0] s;
        logic [PA-1:0] d;
        s = src;
        d = dst;
        for (int i = 0; i < n; i++) begin
            if (i + 1 == err_read) begin
                exp_xfer.push_back('{write: 1'b0, addr: s, data: '0, err: 1'b1});
                return;
            end
            exp_xfer.push_back('{write: 1'b0, addr: s, data: '0, err: 1'b0});
            exp_xfer.push_back('{write: 1'b1, addr: d, data: mem_word(s), err: 1'b0});
            s = s + PA'(8);
            d = d + PA'(8);
        end
    endtask

    task automatic expect_done(input bit err, input int done_cycle, input int busy_cycles);
        exp_done.push_back('{err: err, done_cycle: done_cycle, busy_cycles: busy_cycles});
    endtask

    // Start is high for exactly one cycle (cycle 0); inputs are scrambled
    // afterwards so the copy has to run from latched values.
    task automatic issue(input logic [PA-1:0] src, input logic [PA-1:0] dst, input int n);
        @(negedge HCLK);
        SrcAddr   = src;
        DstAddr   = dst;
        WordCount = LEN_BITS'(n);
        Start     = 1'b1;
        start_cyc = cyc;
        reads_seen = 0;
        @(negedge HCLK);
        Start     = 1'b0;
        SrcAddr   = ~src;
        DstAddr   = ~dst;
        WordCount = LEN_BITS'(7);
    endtask

    task automatic wait_idle(input string name, input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge HCLK);
            #2;
            if (exp_done.size() == 0 && exp_xfer.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_vec++;
            n_bad++;
            $display("FAIL %s_timeout: %0d transfers and %0d Done pulses still pending after %0d cycles",
                     name, exp_xfer.size(), exp_done.size(), budget);
            exp_xfer.delete();
            exp_done.delete();
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},   64'(Busy),   64'd0);
        check({tag, "_done"},   64'(Done),   64'd0);
        check({tag, "_error"},  64'(Error),  64'd0);
        check({tag, "_htrans"}, 64'(HTRANS), 64'(HTRANS_IDLE));
        check({tag, "_hwrite"}, 64'(HWRITE), 64'd0);
        check({tag, "_haddr"},  64'(HADDR),  64'd0);
        check({tag, "_hwdata"}, HWDATA,      64'd0);
    endtask

    // ------------------------------------------------------------------
    // Directed tests
    // ------------------------------------------------------------------
    initial begin
        bit found;

        // Reset state
        repeat (3) @(negedge HCLK);
        check_reset_outputs("reset");
        check("hsize", 64'(HSIZE), 64'd3);
        check("hburst", 64'(HBURST), 64'(HBURST_SINGLE));
        HRESETn = 1'b1;
        repeat (2) @(negedge HCLK);

        // 3-word copy, zero-wait: Done in cycle 13, Busy for 12 cycles
        expect_copy(32'h0000_1000, 32'h8000_0000, 3, 0);
        expect_done(1'b0, 13, 12);
        issue(32'h0000_1000, 32'h8000_0000, 3);
        wait_idle("basic", 40);
        check("basic_busy_after", 64'(Busy), 64'd0);

        // 2 words, 2 wait states per read data phase: 6 cycles/word, Done in 13
        rd_data_waits = 2;
        expect_copy(32'h0000_2000, 32'h8000_1000, 2, 0);
        expect_done(1'b0, 13, 12);
        issue(32'h0000_2000, 32'h8000_1000, 2);
        wait_idle("rd_waits", 40);
        rd_data_waits = 0;

        // Second read errors (1 cycle HREADY=0/HRESP=1, then HREADY=1/HRESP=1):
        // only word 0 is written, Done in cycle 8, Error sticky
        err_read_num = 2;
        expect_copy(32'h0000_3000, 32'h8000_2000, 4, 2);
        expect_done(1'b1, 8, 7);
        issue(32'h0000_3000, 32'h8000_2000, 4);
        wait_idle("rd_error", 40);
        err_read_num = 0;
        repeat (3) @(negedge HCLK);
        #2;
        check("error_sticky", 64'(Error), 64'd1);
        check("error_busy_low", 64'(Busy), 64'd0);

        // Zero-length copy: Done in cycle 1, never Busy, no transfers,
        // and the accepted Start clears the sticky Error
        expect_done(1'b0, 1, 0);
        issue(32'h0000_4000, 32'h8000_3000, 0);
        #2;
        check("zero_len_error_cleared", 64'(Error), 64'd0);
        check("zero_len_htrans", 64'(HTRANS), 64'(HTRANS_IDLE));
        wait_idle("zero_len", 10);

        // Start pulsed again while busy (cycle 3) is ignored
        expect_copy(32'h0000_5000, 32'h8000_4000, 2, 0);
        expect_done(1'b0, 9, 8);
        issue(32'h0000_5000, 32'h8000_4000, 2);
        repeat (2) @(negedge HCLK);
        SrcAddr   = 32'h0000_9000;
        DstAddr   = 32'h8000_9000;
        WordCount = LEN_BITS'(5);
        Start     = 1'b1;
        @(negedge HCLK);
        Start     = 1'b0;
        wait_idle("start_while_busy", 40);

        // Reset asserted during the write address phase
        expect_copy(32'h0000_6000, 32'h8000_5000, 1, 0);
        expect_done(1'b0, 5, 4);
        issue(32'h0000_6000, 32'h8000_5000, 1);
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge HCLK);
            #2;
            if (HTRANS == HTRANS_NONSEQ && HWRITE) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) begin
            n_vec++;
            n_bad++;
            $display("FAIL wra_wait_timeout: write address phase not seen within 10 cycles");
        end
        HRESETn = 1'b0;
        #1;
        check_reset_outputs("midcopy_reset");
        exp_xfer.delete();
        exp_done.delete();
        repeat (2) @(negedge HCLK);
        #2;
        HRESETn = 1'b1;
        // Any Done or transfer in this window is flagged by the monitor.
        repeat (6) @(negedge HCLK);
        check("after_reset_busy", 64'(Busy), 64'd0);
        expect_copy(32'h0000_6000, 32'h8000_5000, 2, 0);
        expect_done(1'b0, 9, 8);
        issue(32'h0000_6000, 32'h8000_5000, 2);
        wait_idle("after_reset", 40);

        // Source at the top of the address space wraps to 0x0; one wait
        // state on each write address phase (5 cycles/word, Done in 11)
        wr_addr_waits = 1;
        expect_copy(32'hFFFF_FFF8, 32'h8000_6000, 2, 0);
        expect_done(1'b0, 11, 10);
        issue(32'hFFFF_FFF8, 32'h8000_6000, 2);
        wait_idle("addr_wrap", 40);
        wr_addr_waits = 0;

        repeat (3) @(negedge HCLK);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_ahb_copy_dma
